ysyx_22050612_mem_arbiter: RTL and testbench

- Shares the single 64-bit data-memory port between two requesters: instruction fetch (IFU, read-only) and load/store (LSU, read/write with byte mask).
- Sits between the IFU/LSU and the memory model, replacing direct combinational memory calls with a valid/ready request and valid response protocol.
- Serialises accesses with one transaction outstanding at a time.
- Applies a response timeout so a dead memory cannot hang the core.

---
 rtl/ysyx_22050612_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22050612_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_mem_arbiter.sv
// IFU/LSU arbiter for the shared data-memory port, one transaction in flight.
// Define YSYX_22050612_ARB_ROUND_ROBIN_EN for round-robin instead of LSU priority.
module ysyx_22050612_mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                grant_lsu
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               grant_q;
  logic               wen_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [MASK_W-1:0]  wmask_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic               pick_lsu;
  logic               hs;
  logic               tmo;
  logic               resp;

  assign hs  = (state_q == IDLE) &&
               (ifu_req_valid || lsu_req_valid);
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

`ifdef YSYX_22050612_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Ties go to whoever did not win the previous handshake.
  assign pick_lsu = lsu_req_valid &&
                    (!ifu_req_valid || !last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else if (hs) begin
      last_q <= pick_lsu;
    end
  end
`else
  assign pick_lsu = lsu_req_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_resp_valid || tmo) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (hs) begin
        grant_q <= pick_lsu;
        wen_q   <= pick_lsu && lsu_wen;
        addr_q  <= pick_lsu ? lsu_addr : ifu_addr;
        wdata_q <= pick_lsu ? lsu_wdata : '0;
        wmask_q <= (pick_lsu && lsu_wen) ? lsu_wmask : '0;
      end
      // A response arriving on the timeout cycle still wins.
      if (state_q == WAIT) begin
        if (mem_resp_valid) begin
          rdata_q <= wen_q ? '0 : mem_rdata;
          err_q   <= 1'b0;
        end else if (tmo) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign resp = (state_q == RESP);

  assign ifu_req_ready  = (state_q == IDLE) &&
                          ifu_req_valid && !pick_lsu;
  assign lsu_req_ready  = (state_q == IDLE) && pick_lsu;

  assign ifu_resp_valid = resp && !grant_q;
  assign ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
  assign ifu_resp_err   = ifu_resp_valid && err_q;
  assign lsu_resp_valid = resp && grant_q;
  assign lsu_rdata      = lsu_resp_valid ? rdata_q : '0;
  assign lsu_resp_err   = lsu_resp_valid && err_q;

  assign mem_req_valid  = (state_q == ISSUE);
  assign mem_wen        = wen_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign grant_lsu      = grant_q;

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed and randomized bench for ysyx_22050612_mem_arbiter.
// Bench acts as IFU, LSU and memory; expectations come from a transaction model.
module tb_ysyx_22050612_mem_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [63:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [63:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic        grant_lsu;

  int n_assert = 0;
  int n_fail   = 0;
  bit last_lsu = 1'b0;

  ysyx_22050612_mem_arbiter #(
    .ADDR_W(64),
    .DATA_W(64),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata(ifu_rdata),
    .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata(lsu_rdata),
    .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata),
    .grant_lsu(grant_lsu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"},
          64'({ifu_req_ready, ifu_resp_valid, ifu_resp_err,
               lsu_req_ready, lsu_resp_valid, lsu_resp_err,
               mem_req_valid, mem_wen, grant_lsu}), 64'd0);
    check({tag, "_ifu_rdata"}, ifu_rdata, 64'd0);
    check({tag, "_lsu_rdata"}, lsu_rdata, 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: requesters, memory ready delay d1, response delay d2.
  task automatic do_txn(input bit iv, input bit lv, input bit lw,
                        input logic [63:0] ia, input logic [63:0] la,
                        input logic [63:0] wd, input logic [7:0] wm,
                        input logic [63:0] rd,
                        input int d1, input int d2);
    bit          g;
    bit          e_wen;
    bit          e_err;
    logic [63:0] e_addr;
    logic [63:0] e_wd;
    logic [7:0]  e_wm;
    logic [63:0] e_rd;
    int          wait_n;
`ifdef YSYX_22050612_ARB_ROUND_ROBIN_EN
    g = lv && (!iv || !last_lsu);
`else
    g = lv;
`endif
    last_lsu = g;
    e_wen  = g && lw;
    e_addr = g ? la : ia;
    e_wd   = g ? wd : 64'd0;
    e_wm   = e_wen ? wm : 8'd0;
    e_err  = (d2 > TMO - 1);
    e_rd   = (e_err || e_wen) ? 64'd0 : rd;
    wait_n = e_err ? TMO : d2 + 1;

    ifu_req_valid = iv;
    ifu_addr      = ia;
    lsu_req_valid = lv;
    lsu_wen       = lw;
    lsu_addr      = la;
    lsu_wdata     = wd;
    lsu_wmask     = wm;
    @(negedge clk);
    check("ifu_req_ready", 64'(ifu_req_ready), 64'(iv && !g));
    check("lsu_req_ready", 64'(lsu_req_ready), 64'(g));
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    ifu_addr  = rand64();
    lsu_addr  = rand64();
    lsu_wdata = rand64();
    lsu_wmask = 8'($urandom);
    lsu_wen   = 1'($urandom);

    for (int i = 0; i <= d1; i++) begin
      mem_req_ready = (i == d1);
      @(negedge clk);
      if (i == 0 || i == d1) begin
        check("mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wen", 64'(mem_wen), 64'(e_wen));
        check("mem_wdata", mem_wdata, e_wd);
        check("mem_wmask", 64'(mem_wmask), 64'(e_wm));
        check("grant_lsu", 64'(grant_lsu), 64'(g));
      end
      step();
    end
    mem_req_ready = 1'b0;

    for (int k = 0; k < wait_n; k++) begin
      mem_resp_valid = (k == d2);
      mem_rdata      = (k == d2) ? rd : rand64();
      @(negedge clk);
      check("wait_quiet",
            64'({mem_req_valid, ifu_resp_valid, lsu_resp_valid}), 64'd0);
      step();
    end
    mem_resp_valid = 1'b0;
    mem_rdata      = rand64();

    ifu_req_valid = 1'($urandom);
    lsu_req_valid = 1'($urandom);
    @(negedge clk);
    check("ifu_resp_valid", 64'(ifu_resp_valid), 64'(!g));
    check("lsu_resp_valid", 64'(lsu_resp_valid), 64'(g));
    check("ifu_rdata", ifu_rdata, g ? 64'd0 : e_rd);
    check("lsu_rdata", lsu_rdata, g ? e_rd : 64'd0);
    check("resp_err", 64'({ifu_resp_err, lsu_resp_err}),
          64'({!g && e_err, g && e_err}));
    check("resp_ready_low", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    check("idle_quiet",
          64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 64'd0);
    step();
  endtask

  initial begin
    rst_n          = 1'b0;
    ifu_req_valid  = 1'b0;
    ifu_addr       = 64'd0;
    lsu_req_valid  = 1'b0;
    lsu_wen        = 1'b0;
    lsu_addr       = 64'd0;
    lsu_wdata      = 64'd0;
    lsu_wmask      = 8'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'd0;

    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Simultaneous requests right after reset: L,L,L or L,I,L.
    for (int n = 0; n < 3; n++)
      do_txn(1, 1, 0, rand64(), rand64(), rand64(), 8'hFF,
             rand64(), 0, 0);

    do_txn(1, 0, 0, 64'h0000_0000_8000_0000, rand64(), rand64(),
           8'h00, 64'h0000_0013_0010_0093, 0, 0);

    do_txn(0, 1, 1, rand64(), 64'h0000_0000_8000_1004,
           64'hDEAD_BEEF_0000_0000, 8'hF0, rand64(), 3, 1);

    do_txn(1, 0, 0, rand64(), rand64(), rand64(), 8'h00,
           rand64(), 1, 20);
    do_txn(0, 1, 0, rand64(), rand64(), rand64(), 8'h0F,
           rand64(), 0, TMO - 1);
    do_txn(1, 0, 0, rand64(), rand64(), rand64(), 8'h00,
           rand64(), 0, 2);

    // Reset while waiting on memory, then a stale response arrives.
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    lsu_addr      = rand64();
    step();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_wait");
    last_lsu = 1'b0;
    step();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = rand64();
    step();
    mem_resp_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("post_rst_quiet",
            64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 64'd0);
      step();
    end

    // Spurious memory response while idle.
    mem_resp_valid = 1'b1;
    mem_rdata      = rand64();
    @(negedge clk);
    check("spurious_quiet",
          64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 64'd0);
    step();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("spurious_after",
          64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 64'd0);
    step();
    do_txn(1, 0, 0, rand64(), rand64(), rand64(), 8'h00,
           rand64(), 0, 0);

    for (int n = 0; n < 60; n++) begin
      bit iv;
      bit lv;
      iv = 1'($urandom);
      lv = 1'($urandom);
      if (!iv && !lv) lv = 1'b1;
      do_txn(iv, lv, 1'($urandom), rand64(), rand64(), rand64(),
             8'($urandom), rand64(), $urandom_range(0, 3),
             $urandom_range(0, TMO + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
